// File: rtl/mem_access_pkg.sv
// Shared types, defaults and byte-lane helpers for the MIPS load/store unit.
// Byte lanes are big-endian: lane 0 is bits [31:24].
package mem_access_pkg;

    localparam int DEFAULT_MEM_WAIT_CYCLES = 5;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } mem_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_CAP,
        ST_WR_WAIT,
        ST_RESP
    } ma_state_t;

    function automatic logic op_is_load(mem_op_t op);
        return op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
    endfunction

    function automatic logic op_misaligned(mem_op_t op, logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        case (op)
            OP_LW, OP_SW:         mis = (lo != 2'b00);
            OP_LH, OP_LHU, OP_SH: mis = lo[0];
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [7:0] lane_byte(logic [31:0] word, logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

    function automatic logic [15:0] lane_half(logic [31:0] word, logic [1:0] lane);
        return lane[1] ? word[15:0] : word[31:16];
    endfunction

    function automatic logic [31:0] extend_load(mem_op_t op, logic [31:0] word, logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = lane_byte(word, lane);
        h = lane_half(word, lane);
        case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'd0, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge_store(mem_op_t op, logic [31:0] word,
                                                logic [31:0] data, logic [1:0] lane);
        logic [31:0] r;
        r = word;
        case (op)
            OP_SB: begin
                case (lane)
                    2'd0:    r[31:24] = data[7:0];
                    2'd1:    r[23:16] = data[7:0];
                    2'd2:    r[15:8]  = data[7:0];
                    default: r[7:0]   = data[7:0];
                endcase
            end
            OP_SH: begin
                if (lane[1]) r[15:0]  = data[15:0];
                else         r[31:16] = data[15:0];
            end
            default: r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_unit_byte_lane.sv
// Combinational load extract/extend and sub-word store merge for one memory word.
module mem_byte_lane
    import mem_access_pkg::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  lane,
    input  logic [31:0] mem_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    assign load_data   = extend_load(op, mem_word, lane);
    assign merged_word = merge_store(op, mem_word, store_data, lane);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a slow word memory; holds each strobe for MEM_WAIT_CYCLES.
// Optional one-word read/write buffer enabled by defining MEM_ACCESS_WORD_BUFFER_EN.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_WAIT_CYCLES = DEFAULT_MEM_WAIT_CYCLES
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam int CNT_W = $clog2(MEM_WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(MEM_WAIT_CYCLES - 1);

    ma_state_t        state, next_state;
    logic [CNT_W-1:0] cnt, next_cnt;
    mem_op_t          op_q;
    logic [31:0]      addr_q, wdata_q, word_q;

    mem_op_t     req_op_e;
    logic        accept, req_mis, buf_hit;
    mem_op_t     lane_op;
    logic [1:0]  lane_sel;
    logic [31:0] lane_word, lane_data, lane_load, lane_merged;

    assign req_op_e = mem_op_t'(req_op);
    assign accept   = req_valid && (state == ST_IDLE);
    assign req_mis  = op_misaligned(req_op_e, req_addr[1:0]);

`ifdef MEM_ACCESS_WORD_BUFFER_EN
    logic        buf_valid;
    logic [29:0] buf_tag;
    logic [31:0] buf_data;

    assign buf_hit = buf_valid && (buf_tag == req_addr[31:2]);

    // The buffer always mirrors the last word that crossed the memory interface.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
        end else if (state == ST_RD_CAP) begin
            buf_valid <= 1'b1;
            buf_tag   <= addr_q[31:2];
            buf_data  <= mem_read_data;
        end else if (state == ST_WR_WAIT && cnt == '0) begin
            buf_valid <= 1'b1;
            buf_tag   <= addr_q[31:2];
            buf_data  <= word_q;
        end
    end

    // Hits are resolved in IDLE straight from the incoming request.
    always_comb begin
        lane_op   = op_q;
        lane_sel  = addr_q[1:0];
        lane_word = mem_read_data;
        lane_data = wdata_q;
        if (state == ST_IDLE) begin
            lane_op   = req_op_e;
            lane_sel  = req_addr[1:0];
            lane_word = buf_data;
            lane_data = req_wdata;
        end
    end
`else
    assign buf_hit = 1'b0;

    always_comb begin
        lane_op   = op_q;
        lane_sel  = addr_q[1:0];
        lane_word = mem_read_data;
        lane_data = wdata_q;
    end
`endif

    mem_byte_lane u_byte_lane (
        .op          (lane_op),
        .lane        (lane_sel),
        .mem_word    (lane_word),
        .store_data  (lane_data),
        .load_data   (lane_load),
        .merged_word (lane_merged)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (req_mis)                                next_state = ST_RESP;
                    else if (req_op_e == OP_SW)                 next_state = ST_WR_WAIT;
                    else if (buf_hit && op_is_load(req_op_e))   next_state = ST_RESP;
                    else if (buf_hit)                           next_state = ST_WR_WAIT;
                    else                                        next_state = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (cnt == '0) next_state = ST_RD_CAP;
                else           next_cnt   = cnt - CNT_W'(1);
            end
            ST_RD_CAP: next_state = op_is_load(op_q) ? ST_RESP : ST_WR_WAIT;
            ST_WR_WAIT: begin
                if (cnt == '0) next_state = ST_RESP;
                else           next_cnt   = cnt - CNT_W'(1);
            end
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
        // Every state entry reloads the counter, so a window always lasts a full MEM_WAIT_CYCLES.
        if (next_state != state) begin
            next_cnt = (next_state == ST_RD_WAIT || next_state == ST_WR_WAIT) ? WAIT_LOAD : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            op_q       <= OP_LW;
            addr_q     <= '0;
            wdata_q    <= '0;
            word_q     <= '0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= req_op_e;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (req_mis) begin
                            resp_rdata <= '0;
                            resp_error <= 1'b1;
                        end else if (req_op_e == OP_SW) begin
                            word_q <= req_wdata;
                        end else if (buf_hit && op_is_load(req_op_e)) begin
                            resp_rdata <= lane_load;
                            resp_error <= 1'b0;
                        end else if (buf_hit) begin
                            word_q <= lane_merged;
                        end
                    end
                end
                ST_RD_CAP: begin
                    if (op_is_load(op_q)) begin
                        resp_rdata <= lane_load;
                        resp_error <= 1'b0;
                    end else begin
                        word_q <= lane_merged;
                    end
                end
                ST_WR_WAIT: begin
                    if (cnt == '0) begin
                        resp_rdata <= '0;
                        resp_error <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready      = (state == ST_IDLE);
    assign resp_valid     = (state == ST_RESP);
    assign mem_read       = (state == ST_RD_WAIT);
    assign mem_write      = (state == ST_WR_WAIT);
    assign mem_address    = {addr_q[31:2], 2'b00};
    assign mem_write_data = word_q;

endmodule
